// File: rtl/fetch_pkg.sv
// Shared types, opcode constants and decode helpers for the multithreaded fetch stage.
package fetch_pkg;
    typedef logic [3:0] thread_idx_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic        long_latency;
    } ifetch_entry_t;

    localparam logic [3:0] BR_PREFIX = 4'b1111;
    localparam logic [2:0] BR_ALWAYS = 3'b011;
    localparam logic [2:0] BR_CALL   = 3'b100;
    localparam logic [2:0] FMT_A     = 3'b110;
    localparam logic [5:0] OP_IMUL   = 6'h0c;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic is_cond_branch(input logic [31:0] w);
        return (w[31:28] == BR_PREFIX) && (w[27:25] inside {3'b000, 3'b001, 3'b010, 3'b101});
    endfunction

    function automatic logic is_uncond_branch(input logic [31:0] w);
        return (w[31:28] == BR_PREFIX) && ((w[27:25] == BR_ALWAYS) || (w[27:25] == BR_CALL));
    endfunction

    function automatic logic is_long_latency(input logic [31:0] w);
        if (w[31:29] == FMT_A) return w[25] || (w[25:20] == OP_IMUL);
        if (!w[31]) return w[27:23] == OP_IMUL[4:0];
        return 1'b0;
    endfunction
endpackage

// File: rtl/branch_predictor_bimodal.sv
// Bimodal table of 2-bit saturating counters; lookups see the pre-update value.
module branch_predictor_bimodal #(
    parameter int BHT_ENTRIES = 256,
    localparam int IW = $clog2(BHT_ENTRIES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] lookup_idx,
    output logic          lookup_taken,
    input  logic          update_valid,
    input  logic [IW-1:0] update_idx,
    input  logic          update_taken
);
    logic [1:0] ctr_q [BHT_ENTRIES];

    assign lookup_taken = ctr_q[lookup_idx][1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (update_valid) begin
            if (update_taken && (ctr_q[update_idx] != 2'b11))
                ctr_q[update_idx] <= ctr_q[update_idx] + 2'd1;
            else if (!update_taken && (ctr_q[update_idx] != 2'b00))
                ctr_q[update_idx] <= ctr_q[update_idx] - 2'd1;
        end
    end
endmodule

// File: rtl/multithread_fetch_stage.sv
// Multithreaded fetch stage: LRU thread pick, icache request/response, per-thread FIFOs.
// Define BIMODAL_PREDICT_EN for the bimodal conditional-branch predictor.
module multithread_fetch_stage
    import fetch_pkg::*;
#(
    parameter int          NUM_THREADS = 4,
    parameter int          IFIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          BHT_ENTRIES = 256,
    localparam int         TIDW        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int         PW          = $clog2(IFIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_THREADS-1:0]   thread_en,
    output logic [31:0]              icache_addr,
    output logic                     icache_request,
    output logic [TIDW-1:0]          icache_req_thread,
    input  logic [31:0]              icache_data,
    input  logic                     icache_hit,
    input  logic                     icache_load_collision,
    input  logic [NUM_THREADS-1:0]   icache_load_complete,
    output logic [NUM_THREADS-1:0]   if_instruction_valid,
    output logic [NUM_THREADS*32-1:0] if_instruction,
    output logic [NUM_THREADS*32-1:0] if_pc,
    output logic [NUM_THREADS-1:0]   if_branch_predicted,
    output logic [NUM_THREADS-1:0]   if_long_latency,
    input  logic [NUM_THREADS-1:0]   ss_instruction_req,
    input  logic [NUM_THREADS-1:0]   rb_rollback,
    input  logic [NUM_THREADS*32-1:0] rb_rollback_pc,
    input  logic                     bp_update_valid,
    input  logic [31:0]              bp_update_pc,
    input  logic                     bp_update_taken
);
    ifetch_entry_t          fifo_q   [NUM_THREADS][IFIFO_DEPTH];
    logic [PW-1:0]          rd_ptr_q [NUM_THREADS];
    logic [PW-1:0]          wr_ptr_q [NUM_THREADS];
    logic [PW:0]            count_q  [NUM_THREADS];
    logic [31:0]            pc_q     [NUM_THREADS];
    logic [31:0]            pc_d     [NUM_THREADS];
    logic [TIDW-1:0]        order_q  [NUM_THREADS];
    logic [TIDW-1:0]        order_d  [NUM_THREADS];
    logic [NUM_THREADS-1:0] waiting_q, waiting_d;
    logic [TIDW-1:0]        last_req_q;
    logic                   req_pend_q;

    logic [31:0]            swapped_w, fetch_pc, branch_tgt;
    logic                   resp_hit, resp_miss, cond_taken, pred;
    logic [NUM_THREADS-1:0] hit_t, enq, deq, full, almost_full, elig;
    logic                   grant_vld;
    logic [TIDW-1:0]        grant;
    ifetch_entry_t          new_entry;

    assign swapped_w  = bswap32(icache_data);
    assign fetch_pc   = pc_q[last_req_q];
    assign branch_tgt = fetch_pc + 32'd4 + {{12{swapped_w[24]}}, swapped_w[24:5]};
    assign resp_hit   = req_pend_q && icache_hit;
    assign resp_miss  = req_pend_q && !icache_hit && !icache_load_collision;

`ifdef BIMODAL_PREDICT_EN
    localparam int IW = $clog2(BHT_ENTRIES);
    logic unused_bp;
    assign unused_bp = ^{bp_update_pc[31:IW+2], bp_update_pc[1:0]};

    branch_predictor_bimodal #(.BHT_ENTRIES(BHT_ENTRIES)) u_bp (
        .clk          (clk),
        .reset        (reset),
        .lookup_idx   (fetch_pc[IW+1:2]),
        .lookup_taken (cond_taken),
        .update_valid (bp_update_valid),
        .update_idx   (bp_update_pc[IW+1:2]),
        .update_taken (bp_update_taken)
    );
`else
    // Static backward-taken: the offset sign bit decides.
    logic unused_bp;
    assign unused_bp  = ^{bp_update_valid, bp_update_pc, bp_update_taken} ^ (BHT_ENTRIES == 0);
    assign cond_taken = swapped_w[24];
`endif

    assign pred      = is_uncond_branch(swapped_w) || (is_cond_branch(swapped_w) && cond_taken);
    assign new_entry = '{pc: fetch_pc + 32'd4, instr: swapped_w, pred: pred,
                         long_latency: is_long_latency(swapped_w)};

    // Rollback outranks everything: it flushes, clears waiting and redirects the PC.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            hit_t[t]       = resp_hit && (last_req_q == TIDW'(t));
            enq[t]         = hit_t[t] && !rb_rollback[t];
            deq[t]         = ss_instruction_req[t] && (count_q[t] != '0) && !rb_rollback[t];
            full[t]        = count_q[t] == (PW+1)'(IFIFO_DEPTH);
            almost_full[t] = count_q[t] == (PW+1)'(IFIFO_DEPTH - 1);
            waiting_d[t]   = !rb_rollback[t] &&
                             ((waiting_q[t] && !icache_load_complete[t]) ||
                              (resp_miss && (last_req_q == TIDW'(t))));
            if (rb_rollback[t])  pc_d[t] = rb_rollback_pc[t*32 +: 32];
            else if (hit_t[t])   pc_d[t] = pred ? branch_tgt : fetch_pc + 32'd4;
            else                 pc_d[t] = pc_q[t];
            elig[t] = thread_en[t] && !full[t] && !(almost_full[t] && enq[t]) && !waiting_d[t];
        end
    end

    // order_q[0] is the least recently granted thread; the winner moves to the tail.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 0; k < NUM_THREADS; k++) order_d[k] = order_q[k];
        for (int k = 0; k < NUM_THREADS; k++) begin
            if (!grant_vld && elig[order_q[k]]) begin
                grant_vld = 1'b1;
                grant     = order_q[k];
            end
            if (grant_vld && (k < NUM_THREADS - 1)) order_d[k] = order_q[(k + 1) % NUM_THREADS];
        end
        if (grant_vld) order_d[NUM_THREADS-1] = grant;
    end

    assign icache_request    = reset && grant_vld;
    assign icache_req_thread = grant;
    assign icache_addr       = pc_d[grant];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waiting_q  <= '0;
            last_req_q <= '0;
            req_pend_q <= 1'b0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t]     <= RESET_PC;
                rd_ptr_q[t] <= '0;
                wr_ptr_q[t] <= '0;
                count_q[t]  <= '0;
                order_q[t]  <= TIDW'(t);
            end
        end else begin
            waiting_q  <= waiting_d;
            req_pend_q <= grant_vld;
            if (grant_vld) last_req_q <= grant;
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t]    <= pc_d[t];
                order_q[t] <= order_d[t];
                if (rb_rollback[t]) begin
                    rd_ptr_q[t] <= '0;
                    wr_ptr_q[t] <= '0;
                    count_q[t]  <= '0;
                end else begin
                    if (enq[t]) wr_ptr_q[t] <= wr_ptr_q[t] + PW'(1);
                    if (deq[t]) rd_ptr_q[t] <= rd_ptr_q[t] + PW'(1);
                    count_q[t] <= count_q[t] + (PW+1)'(enq[t]) - (PW+1)'(deq[t]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int t = 0; t < NUM_THREADS; t++)
            if (enq[t]) fifo_q[t][wr_ptr_q[t]] <= new_entry;
    end

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            if_instruction_valid[t]    = count_q[t] != '0;
            if_instruction[t*32 +: 32] = fifo_q[t][rd_ptr_q[t]].instr;
            if_pc[t*32 +: 32]          = fifo_q[t][rd_ptr_q[t]].pc;
            if_branch_predicted[t]     = fifo_q[t][rd_ptr_q[t]].pred;
            if_long_latency[t]         = fifo_q[t][rd_ptr_q[t]].long_latency;
        end
    end

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_rb_chk
        a_rb_pc_nonzero: assert property (@(posedge clk) disable iff (!reset)
            !(rb_rollback[t] && (rb_rollback_pc[t*32 +: 32] == 32'h0)))
            else $error("rollback to PC 0 on thread %0d", t);
    end
endmodule

// File: doc/multithread_fetch_stage.md
Name: multithread_fetch_stage

Overview:
Parametrised next-generation instruction fetch stage for N hardware threads. Keeps a per-thread instruction FIFO filled from the L1 instruction cache, picks threads LRU-fairly, and tracks outstanding misses. Byte-swaps fetched words, pre-decodes long-latency ops and predicts branches. Adds a per-thread enable mask, a configurable reset PC, rollback-wins-over-hit ordering and an optional bimodal predictor. Sits between the icache and the thread select stage.

Parameters:
NUM_THREADS, 4, hardware threads (1..16)
IFIFO_DEPTH, 4, entries per thread instruction FIFO (power of 2, >=2)
RESET_PC, 32'h0, PC loaded into every thread on reset
BHT_ENTRIES, 256, bimodal table entries (power of 2); unused without the optional feature

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
thread_en  in  NUM_THREADS  thread may fetch
icache_addr  out  32  fetch address
icache_request  out  1  fetch request this cycle
icache_req_thread  out  $clog2(NUM_THREADS)  requesting thread index
icache_data  in  32  little-endian word; valid the cycle after request
icache_hit  in  1  hit for previous-cycle request
icache_load_collision  in  1  previous request neither hit nor missed; retry
icache_load_complete  in  NUM_THREADS  miss fill done, per thread
if_instruction_valid  out  NUM_THREADS  FIFO non-empty
if_instruction  out  NUM_THREADS*32  byte-swapped instruction
if_pc  out  NUM_THREADS*32  fetch PC + 4
if_branch_predicted  out  NUM_THREADS  predicted taken
if_long_latency  out  NUM_THREADS  long-latency op
ss_instruction_req  in  NUM_THREADS  dequeue head, if valid
rb_rollback  in  NUM_THREADS  rollback thread
rb_rollback_pc  in  NUM_THREADS*32  rollback target
bp_update_valid  in  1  branch resolved (optional feature)
bp_update_pc  in  32  PC of resolved branch
bp_update_taken  in  1  resolved direction

Behaviour:
- Reset (reset low):
  - every PC = RESET_PC; waiting mask and last-request register = 0; FIFOs empty.
  - if_instruction_valid = 0 and icache_request = 0 while reset is low.
  - other if_* data outputs are undefined while the valid bit is 0.
- Eligible thread: thread_en & ~fifo_full & ~(almost_full & enqueue this cycle) & ~waiting_nxt.
- Arbitration:
  - LRU arbiter grants one eligible thread per cycle; LRU is updated on every grant.
  - icache_addr = that thread's pc_nxt.
- Response:
  - Arrives the cycle after the request and applies to last_req.
  - hit: enqueue {pc+4, swapped data, pred, long_latency}.
  - miss (not hit, not collision): set waiting[last_req].
  - collision: no enqueue, no waiting; the PC is unchanged, so the thread re-arbitrates.
- Waiting clear: waiting bit cleared by icache_load_complete; a same-cycle miss set for the same thread wins.
- pc_nxt priority, per thread:
  1. rollback -> rb_rollback_pc.
  2. Not hit, or not last_req -> hold.
  3. predicted -> pc + 4 + sign_extend(data[24:5]).
  4. Otherwise -> pc + 4.
- Rollback on thread t:
  - flushes FIFO t and clears waiting[t].
  - suppresses a same-cycle hit enqueue for t.
  - an enqueue to another thread is unaffected.
- thread_en deassert:
  - stops new requests only.
  - an in-flight response still completes; FIFO contents are kept.
- Dequeue and enqueue may occur together on a full FIFO minus one; there is no overflow because of the almost_full rule.
- Pre-decode (swapped word w):
  - Format A (w[31:29]=110): long latency if w[25] or w[25:20]==OP_IMUL.
  - Format B (w[31]=0): long latency if w[27:23]==OP_IMUL.
  - Otherwise 0.
- Branch classes: w[31:28]=1111, and w[27:25] ∈ {000,001,010,101} is conditional, 011 is always, 100 is call.
- Default prediction: always/call taken; conditional taken if the offset is negative.
- Arithmetic: PC math is modulo 2^32; wrap-around is silent.
- Assertion: a rollback PC of 0 is flagged (simulation only).

Optional Feature:
Macro BIMODAL_PREDICT_EN.
- Defined:
  - Table of BHT_ENTRIES 2-bit saturating counters, indexed by pc[$clog2(BHT_ENTRIES)+1:2], reset to 2'b01.
  - Conditional branches are predicted taken if counter[1]; always/call stay taken.
  - bp_update_valid increments (taken) or decrements (not taken), saturating at 3/0.
  - A read and an update to the same index in one cycle returns the pre-update value.
- Undefined: static backward-taken prediction; the bp_update_* ports are ignored and no table exists.

Decomposition:
- Shared package (fetch_pkg): thread_idx_t, ifetch_entry_t {pc, instr, pred, long_latency}, branch-class opcode constants, OP_IMUL.
- Reuse the existing arbiter, one_hot_to_index and sync_fifo.
- One new sub-module: branch_predictor_bimodal (table, lookup, update). It is instantiated only under BIMODAL_PREDICT_EN.

Test Plan:
- Reset, RESET_PC=32'h1000, all threads enabled, always hit -> thread 0 requests 0x1000 first; grants rotate 0,1,2,3; if_pc for the first thread 0 entry = 0x1004.
- Thread 1 misses at 0x2000 -> thread 1 not requested until icache_load_complete[1]; it then re-requests 0x2000; other threads keep fetching every cycle.
- Hit returns a backward conditional branch (offset -4) at pc 0x3000 -> if_branch_predicted=1; next request 0x3000; same with offset +8 -> predicted 0, next 0x3004.
- rb_rollback[2] with pc 0x4000 in the same cycle as a thread-2 hit -> no enqueue, FIFO 2 empty next cycle, next thread-2 request 0x4000.
- Fill FIFO 0 to IFIFO_DEPTH with ss_instruction_req=0 -> no thread-0 request once almost_full with a pending enqueue; exactly IFIFO_DEPTH entries; one dequeue re-enables it.
- BIMODAL_PREDICT_EN: two taken updates for pc 0x5000 -> a forward branch at 0x5000 is predicted taken; two not-taken updates -> not taken.
